// File: rtl/display_pkg.sv
// Shared types for the pixel-timing receiver: lock FSM states and counter limits.
// No clocked logic here.
package display_pkg;

    typedef enum logic [1:0] {
        SEARCH  = 2'd0,
        MEASURE = 2'd1,
        LOCKED  = 2'd2
    } rx_state_t;

    // Largest positive value of a signed counter of width w.
    function automatic int sat_max(input int w);
        return (1 << (w - 1)) - 1;
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Polarity-normalised, registered copy of a timing pin plus a rising-edge pulse.
// Level is one clk_pix behind the pin, the pulse is combinational off the two flops; never stalls.
module sync_edge_det #(
    parameter bit POL = 1'b1
) (
    input  logic clk_pix,
    input  logic rst_pix_n,
    input  logic pin,
    output logic lvl,
    output logic rise
);

    logic lvl_d;

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            lvl   <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            lvl   <= POL ? pin : ~pin;
            lvl_d <= lvl;
        end
    end

    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/display_timing_rx.sv
// Recovers sx/sy and sync strobes from hsync/vsync/de, measures geometry and locks to the expected mode.
// Pin-to-output latency 2 clk_pix; no backpressure, the video source is never stalled.
module display_timing_rx
    import display_pkg::*;
#(
    parameter int CORDW       = 16,
    parameter int H_RES       = 640,
    parameter int V_RES       = 480,
    parameter int H_TOTAL     = 800,
    parameter int V_TOTAL     = 525,
    parameter int H_POL       = 0,
    parameter int V_POL       = 0,
    parameter int LOCK_FRAMES = 2
) (
    input  logic                    clk_pix,
    input  logic                    rst_pix_n,
    input  logic                    hsync,
    input  logic                    vsync,
    input  logic                    de,
    output logic signed [CORDW-1:0] sx,
    output logic signed [CORDW-1:0] sy,
    output logic                    de_o,
    output logic                    frame,
    output logic                    line,
    output logic                    locked,
    output logic        [CORDW-1:0] meas_h_act,
    output logic        [CORDW-1:0] meas_h_tot,
    output logic        [CORDW-1:0] meas_v_act,
    output logic        [CORDW-1:0] meas_v_tot,
    output logic                    meas_valid,
    output logic                    err
);

    localparam logic [CORDW-1:0] CMAX = CORDW'(sat_max(CORDW));

    function automatic logic [CORDW-1:0] inc_sat(input logic [CORDW-1:0] v);
        return (v == CMAX) ? v : v + CORDW'(1);
    endfunction

    logic hs_lvl, vs_lvl, de_lvl;
    logic hs_rise, vs_rise, de_rise, de_fall;

    sync_edge_det #(.POL(H_POL != 0)) u_hs (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pin       (hsync),
        .lvl       (hs_lvl),
        .rise      (hs_rise)
    );

    sync_edge_det #(.POL(V_POL != 0)) u_vs (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pin       (vsync),
        .lvl       (vs_lvl),
        .rise      (vs_rise)
    );

    sync_edge_det #(.POL(1'b1)) u_de (
        .clk_pix   (clk_pix),
        .rst_pix_n (rst_pix_n),
        .pin       (de),
        .lvl       (de_lvl),
        .rise      (de_rise)
    );

    // Sync levels are only needed as edges; de_o already holds the previous de level.
    logic unused_lvl;
    assign unused_lvl = hs_lvl ^ vs_lvl;
    assign de_fall    = de_o & ~de_lvl;

    logic [CORDW-1:0] hcnt, hact, vcnt, vact, hact_base;
    rx_state_t        state_q, state_d;
    logic [7:0]       match_cnt, match_d;
    logic             locked_d, err_d, mv_d, meas_load, timeout, frame_ok;

    assign hact_base = hs_rise ? '0 : hact;

    // vcnt/vact still hold the finishing frame in the vs-edge cycle.
    assign frame_ok = (meas_h_act == CORDW'(H_RES))   && (meas_h_tot == CORDW'(H_TOTAL)) &&
                      (vact       == CORDW'(V_RES))   && (vcnt       == CORDW'(V_TOTAL));
    assign timeout  = (state_q != SEARCH) && !hs_rise && (hcnt == CORDW'(2 * H_TOTAL));

    always_comb begin
        state_d   = state_q;
        match_d   = match_cnt;
        locked_d  = locked;
        err_d     = 1'b0;
        mv_d      = 1'b0;
        meas_load = 1'b0;
        if (timeout) begin
            state_d  = SEARCH;
            match_d  = '0;
            locked_d = 1'b0;
            err_d    = 1'b1;
        end else if (vs_rise) begin
            case (state_q)
                SEARCH: begin
                    state_d = MEASURE;
                    match_d = '0;
                end
                MEASURE: begin
                    meas_load = 1'b1;
                    mv_d      = 1'b1;
                    if (frame_ok) begin
                        match_d = match_cnt + 8'd1;
                        if (match_cnt + 8'd1 >= 8'(LOCK_FRAMES)) begin
                            state_d  = LOCKED;
                            locked_d = 1'b1;
                        end
                    end else begin
                        match_d = '0;
                        err_d   = 1'b1;
                    end
                end
                LOCKED: begin
                    meas_load = 1'b1;
                    mv_d      = 1'b1;
                    if (!frame_ok) begin
                        state_d  = MEASURE;
                        match_d  = '0;
                        locked_d = 1'b0;
                        err_d    = 1'b1;
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    always_ff @(posedge clk_pix) begin
        if (!rst_pix_n) begin
            state_q    <= SEARCH;
            match_cnt  <= '0;
            locked     <= 1'b0;
            err        <= 1'b0;
            meas_valid <= 1'b0;
            frame      <= 1'b0;
            line       <= 1'b0;
            de_o       <= 1'b0;
            sx         <= '0;
            sy         <= '0;
            hcnt       <= '0;
            hact       <= '0;
            vcnt       <= '0;
            vact       <= '0;
            meas_h_act <= '0;
            meas_h_tot <= '0;
            meas_v_act <= '0;
            meas_v_tot <= '0;
        end else begin
            state_q    <= state_d;
            match_cnt  <= match_d;
            locked     <= locked_d;
            err        <= err_d;
            meas_valid <= mv_d;
            frame      <= vs_rise;
            line       <= hs_rise;
            de_o       <= de_lvl;
            sx         <= de_rise ? '0 : inc_sat(sx);
            if (vs_rise)      sy <= '1;
            else if (de_rise) sy <= inc_sat(sy);
            hcnt       <= hs_rise ? '0 : inc_sat(hcnt);
            hact       <= de_lvl ? inc_sat(hact_base) : hact_base;
            // A line starting on the vs edge belongs to the new frame.
            if (vs_rise)      vcnt <= hs_rise ? CORDW'(1) : '0;
            else if (hs_rise) vcnt <= inc_sat(vcnt);
            if (vs_rise)      vact <= '0;
            else if (de_rise) vact <= inc_sat(vact);
            if (hs_rise)      meas_h_tot <= inc_sat(hcnt);
            if (de_fall)      meas_h_act <= hact;
            if (meas_load) begin
                meas_v_tot <= vcnt;
                meas_v_act <= vact;
            end
        end
    end

endmodule
